// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP value and opcode field.
package fetch_stage_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // Bubble instruction; zero-extended to the instruction width where used.
  localparam int unsigned NOP_INSTR = 0;

  // Opcode occupies the top OPCODE_W bits of the instruction word.
  localparam int unsigned OPCODE_W = 6;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble (and reset) clears, load captures, otherwise holds.
module fetch_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc_next_in,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_next,
  output logic              valid
);

  logic [DATA_W-1:0] instr_reg;
  logic [ADDR_W-1:0] pc_next_reg;
  logic              valid_reg;

  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      instr_reg   <= DATA_W'(NOP_INSTR);
      pc_next_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (load) begin
      instr_reg   <= instr_in;
      pc_next_reg <= pc_next_in;
      valid_reg   <= 1'b1;
    end
  end

  assign instr   = instr_reg;
  assign pc_next = pc_next_reg;
  assign valid   = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, RUN/HALTED FSM, saturating fetch counter and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       PC_INC      = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = 6'h3F,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc_next,
  output logic              if_id_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]  fetch_count_reg;
  logic [ADDR_W-1:0] pc_plus;
  logic              is_halt;
  logic              ifid_load, ifid_bubble, count_inc;

  assign pc_plus = pc_reg + ADDR_W'(PC_INC);
  assign is_halt = (imem_rdata[DATA_W-1 -: OPCODE_W] == HALT_OPCODE[OPCODE_W-1:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      pc_reg          <= RESET_PC;
      fetch_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (count_inc && (fetch_count_reg != {CNT_W{1'b1}}))
        fetch_count_reg <= fetch_count_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (redirect_valid)
      state_next = ST_RUN;
    else if (!stall && (state_reg == ST_RUN) && is_halt)
      state_next = ST_HALTED;
  end

  // Redirect beats stall; a halt instruction is still delivered but the PC parks on it.
  always_comb begin
    pc_next     = pc_reg;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    count_inc   = 1'b0;
    if (redirect_valid) begin
      pc_next     = redirect_pc;
      ifid_bubble = 1'b1;
    end else if (!stall) begin
      case (state_reg)
        ST_RUN: begin
          ifid_load = 1'b1;
          count_inc = 1'b1;
          if (!is_halt)
            pc_next = pc_plus;
        end
        ST_HALTED: ifid_bubble = 1'b1;
        default:   ifid_bubble = 1'b1;
      endcase
    end
  end

  fetch_if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clock      (clock),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr_in   (imem_rdata),
    .pc_next_in (pc_plus),
    .instr      (if_id_instr),
    .pc_next    (if_id_pc_next),
    .valid      (if_id_valid)
  );

  assign imem_addr   = pc_reg;
  assign halted      = (state_reg == ST_HALTED);
  assign fetch_count = fetch_count_reg;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 32, PC and address width.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter PC_INC, default 1, PC increment (word-addressed memory).
REQ-004 Parameter RESET_PC, default 0, PC value after reset.
REQ-005 Parameter HALT_OPCODE, default 6'h3F, opcode in instr[DATA_W-1 -: 6] that halts fetch.
REQ-006 Parameter CNT_W, default 16, fetch-counter width.
REQ-007 clock  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  reset, synchronous and active-high.
REQ-009 stall  in  1  hazard stall; hold PC and IF/ID.
REQ-010 redirect_valid  in  1  taken branch/jump from a later stage.
REQ-011 redirect_pc  in  ADDR_W  redirect target.
REQ-012 imem_addr  out  ADDR_W  instruction-memory address, equals PC combinationally.
REQ-013 imem_rdata  in  DATA_W  instruction at imem_addr, same-cycle combinational read.
REQ-014 if_id_instr  out  DATA_W  registered instruction to decode.
REQ-015 if_id_pc_next  out  ADDR_W  registered PC+PC_INC of that instruction.
REQ-016 if_id_valid  out  1  IF/ID holds a real instruction.
REQ-017 halted  out  1  state is HALTED.
REQ-018 fetch_count  out  CNT_W  count of instructions loaded into IF/ID with valid=1.

Function
REQ-019 States: RUN, HALTED; priority per edge: reset > redirect_valid > stall > state action.
REQ-020 Bubble: if_id_instr=0 (NOP), if_id_valid=0, if_id_pc_next=0.
REQ-021 RUN, no stall/redirect: PC <= PC+PC_INC modulo 2^ADDR_W; IF/ID <= {imem_rdata, PC+PC_INC, 1}; fetch_count increments.
REQ-022 RUN, imem_rdata opcode == HALT_OPCODE: halt instruction loaded into IF/ID as in REQ-021 and counted, PC holds, state <= HALTED.
REQ-023 HALTED, no stall/redirect: PC holds, IF/ID loads bubble, fetch_count holds.
REQ-024 redirect_valid (either state, regardless of stall): PC <= redirect_pc, IF/ID loads bubble, state <= RUN, fetch_count holds.
REQ-025 stall without redirect: PC, IF/ID, state, fetch_count all hold.
REQ-026 fetch_count saturates at 2^CNT_W-1; no wrap.
REQ-027 PC wrap: PC = 2^ADDR_W-PC_INC advances to 0 with no error indication.
REQ-028 halted is a direct decode of state register; no combinational path from inputs.
REQ-029 Redirect latency 1 cycle: imem_addr = redirect_pc in the cycle after redirect_valid sampled.

Reset
REQ-030 On reset edge: PC=RESET_PC, IF/ID = bubble, state=RUN, fetch_count=0, overriding all inputs.
REQ-031 Reset mid-operation (including in HALTED or during stall) yields the same state as REQ-030 on the next cycle.

Structure
REQ-032 Shared package holds state encoding (RUN=0, HALTED=1), NOP value 0, and opcode field offset/width.
REQ-033 One sub-module, fetch_if_id_reg, holding the IF/ID register with load, bubble and hold controls; PC and FSM live in fetch_stage.

Verification
REQ-034 Reset, imem returns 0x20010005 at every address, 4 cycles -> imem_addr 0,1,2,3,4; if_id_pc_next 1,2,3,4; fetch_count=4.
REQ-035 stall=1 for 2 cycles at PC=3 -> imem_addr stays 3, IF/ID and fetch_count unchanged, resume at 4.
REQ-036 redirect_valid=1, redirect_pc=0x40, stall=1 same cycle -> next cycle imem_addr=0x40, if_id_valid=0.
REQ-037 imem_rdata=0xFC000000 at PC=5 -> next cycle halted=1, if_id_instr=0xFC000000 valid=1; following cycle if_id_valid=0, imem_addr stays 5; redirect to 0x10 clears halted.
REQ-038 CNT_W=2, 5 valid fetches -> fetch_count 1,2,3,3,3; ADDR_W=4 from PC=15 -> PC 0.
REQ-039 reset asserted while HALTED with stall=1 -> PC=RESET_PC, halted=0, fetch_count=0, if_id_valid=0.
